// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration sequencer.
//   state_t    : sequencer FSM encoding (INIT_WAIT, LOAD, PULSE, RUN)
//   mode_t     : synchronised mode_sel encoding
//   profile_t  : divider / nominal duty / coarse step / fine step for one mode
//   PROF_*     : profiles computed from the default dividers
//   clamp()    : saturating limit used for pending and duty arithmetic
package pwm_cfg_pkg;

  typedef enum logic [1:0] {INIT_WAIT, LOAD, PULSE, RUN} state_t;

  // Bit1 dominates: 1x selects the slow profile regardless of bit0.
  typedef enum logic [1:0] {
    MODE_FAST     = 2'b00,
    MODE_MID      = 2'b01,
    MODE_SLOW     = 2'b10,
    MODE_SLOW_ALT = 2'b11
  } mode_t;

  localparam int DEF_DIV_FAST = 10;
  localparam int DEF_DIV_MID  = 20;
  localparam int DEF_DIV_SLOW = 100;

  typedef struct packed {
    int div;
    int nominal;
    int coarse;
    int fine;
  } profile_t;

  function automatic profile_t make_profile(input int div);
    profile_t p;
    p.div     = div;
    p.nominal = div / 2;
    p.coarse  = div / 10;
    p.fine    = (div / 100 < 1) ? 1 : div / 100;
    return p;
  endfunction

  localparam profile_t PROF_FAST = make_profile(DEF_DIV_FAST);
  localparam profile_t PROF_MID  = make_profile(DEF_DIV_MID);
  localparam profile_t PROF_SLOW = make_profile(DEF_DIV_SLOW);

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pwm_cfg_sync2.sv
// Two-flop synchroniser for one asynchronous bit.
//   clk  : destination clock
//   srst : synchronous active-high reset, clears both flops
//   d    : asynchronous input
//   q    : synchronised output (2 clk latency)
module pwm_cfg_sync2 (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Configuration sequencer for the PWM generator.
// Owns div_value / duty_count, sequences power-up and mode changes, and
// folds duty-adjust pulses into saturating updates.
// Ports:
//   clk, srst        : clock, synchronous active-high reset
//   mode_sel[1:0]    : raw async mode switch (synchronised internally)
//   inc/dec_coarse   : duty +/- coarse step pulses
//   inc/dec_fine     : duty +/- fine step pulses
//   period_end       : generator's last-cycle-of-period pulse
//   div_value        : active period divider
//   duty_count       : active high-time count
//   gen_srst         : one-cycle generator reset (PULSE state)
//   cfg_valid        : configuration stable
//   busy             : not in RUN
// Build option: define PWM_CFG_IMMEDIATE_EN to apply adjust deltas to
// duty_count every cycle instead of accumulating until period_end.
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT_CYCLES = 15,
  parameter int DIV_FAST    = DEF_DIV_FAST,
  parameter int DIV_MID     = DEF_DIV_MID,
  parameter int DIV_SLOW    = DEF_DIV_SLOW
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [1:0]       mode_sel,
  input  logic             inc_coarse,
  input  logic             dec_coarse,
  input  logic             inc_fine,
  input  logic             dec_fine,
  input  logic             period_end,
  output logic [WIDTH-1:0] div_value,
  output logic [WIDTH-1:0] duty_count,
  output logic             gen_srst,
  output logic             cfg_valid,
  output logic             busy
);

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  localparam profile_t P_FAST = make_profile(DIV_FAST);
  localparam profile_t P_MID  = make_profile(DIV_MID);
  localparam profile_t P_SLOW = make_profile(DIV_SLOW);

  logic [1:0]              mode_s;
  mode_t                   active_mode;
  state_t                  state, state_nx;
  logic [CW-1:0]           init_cnt;
  logic signed [WIDTH+1:0] pending;
  profile_t                prof;
  logic                    mode_chg;
  int                      delta;
  int                      duty_upd;
`ifndef PWM_CFG_IMMEDIATE_EN
  int                      pend_sum;
`endif

  // Per-bit synchroniser array; only mode_s is used downstream.
  pwm_cfg_sync2 u_sync [1:0] (
    .clk  (clk),
    .srst (srst),
    .d    (mode_sel),
    .q    (mode_s)
  );

  always_comb begin
    prof = P_FAST;
    if (mode_s[1])      prof = P_SLOW;
    else if (mode_s[0]) prof = P_MID;
  end

  assign mode_chg = (mode_s != active_mode);

  // Algebraic sum of this cycle's adjust pulses.
  always_comb begin
    delta = 0;
    if (inc_coarse) delta = delta + prof.coarse;
    if (dec_coarse) delta = delta - prof.coarse;
    if (inc_fine)   delta = delta + prof.fine;
    if (dec_fine)   delta = delta - prof.fine;
  end

`ifdef PWM_CFG_IMMEDIATE_EN
  always_comb begin
    duty_upd = clamp(int'(duty_count) + delta, 0, int'(div_value));
  end
`else
  // A delta coinciding with period_end is folded in before the commit.
  always_comb begin
    pend_sum = clamp(int'(pending) + delta, -int'(div_value), int'(div_value));
    duty_upd = clamp(int'(duty_count) + pend_sum, 0, int'(div_value));
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      INIT_WAIT: if (init_cnt == CW'(INIT_CYCLES - 1)) state_nx = LOAD;
      LOAD:      state_nx = PULSE;
      PULSE:     state_nx = RUN;
      RUN:       if (mode_chg) state_nx = LOAD;
      default:   state_nx = INIT_WAIT;
    endcase
  end

  assign gen_srst  = (state == PULSE);
  assign busy      = (state != RUN);
  // Drop valid already in the cycle a mode change is detected, so the
  // outgoing configuration is never reported stable once it is stale.
  assign cfg_valid = (state == RUN) && !mode_chg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= INIT_WAIT;
      div_value   <= WIDTH'(DIV_FAST);
      duty_count  <= WIDTH'(DIV_FAST / 2);
      pending     <= '0;
      init_cnt    <= '0;
      active_mode <= MODE_FAST;
    end else begin
      state <= state_nx;
      case (state)
        INIT_WAIT: init_cnt <= init_cnt + CW'(1);
        LOAD: begin
          active_mode <= mode_t'(mode_s);
          div_value   <= WIDTH'(prof.div);
          duty_count  <= WIDTH'(prof.nominal);
          pending     <= '0;
        end
        RUN: begin
`ifdef PWM_CFG_IMMEDIATE_EN
          duty_count <= WIDTH'(duty_upd);
          pending    <= '0;
`else
          if (period_end) begin
            duty_count <= WIDTH'(duty_upd);
            pending    <= '0;
          end else begin
            pending    <= (WIDTH+2)'(pend_sum);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
module tb_pwm_cfg_sequencer;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [1:0] mode_sel = 2'b00;
  logic       inc_coarse = 1'b0, dec_coarse = 1'b0, inc_fine = 1'b0, dec_fine = 1'b0;
  logic       period_end = 1'b0;
  logic [7:0] div_value, duty_count;
  logic       gen_srst, cfg_valid, busy;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];   // {div_value, duty_count} expected at the next output event
  logic [15:0] exp;

  pwm_cfg_sequencer dut (
    .clk(clk), .srst(srst), .mode_sel(mode_sel),
    .inc_coarse(inc_coarse), .dec_coarse(dec_coarse),
    .inc_fine(inc_fine), .dec_fine(dec_fine), .period_end(period_end),
    .div_value(div_value), .duty_count(duty_count),
    .gen_srst(gen_srst), .cfg_valid(cfg_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic commit;
    period_end = 1'b1; tick(); period_end = 1'b0;
  endtask

  // Moves to mode m and stops in the first RUN cycle after gen_srst.
  task automatic switch_mode(input logic [1:0] m);
    int n;
    n = 0;
    mode_sel = m;
    tick();
    while (gen_srst !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL switch_timeout: waited %0d cycles, required gen_srst", n); end
    tick();
  endtask

  task automatic test_reset;
    int n, pulses;
    srst = 1'b1; tick(); srst = 1'b0;
    checks++;
    if (div_value !== 8'd10 || duty_count !== 8'd5 || busy !== 1'b1 || gen_srst !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: div=%0d duty=%0d busy=%b gen=%b valid=%b, required 10 5 1 0 0",
               div_value, duty_count, busy, gen_srst, cfg_valid);
    end
    exp_q.push_back({8'd10, 8'd5});
    n = 0; pulses = 0;
    while (busy === 1'b1 && n < 100) begin
      if (gen_srst === 1'b1) pulses++;
      n++;
      tick();
    end
    checks++;
    if (n !== 17) begin errors++; $display("FAIL powerup_busy_cycles: got %0d, required 17", n); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL powerup_gen_srst_pulses: got %0d, required 1", pulses); end
    exp = exp_q.pop_front();
    checks++;
    if (cfg_valid !== 1'b1 || div_value !== exp[15:8] || duty_count !== exp[7:0]) begin
      errors++;
      $display("FAIL powerup_cfg: valid=%b div=%0d duty=%0d, required 1 %0d %0d", cfg_valid, div_value, duty_count, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_boundary;
    exp_q.push_back({8'd10, 8'd6});
    inc_coarse = 1'b1; tick(); inc_coarse = 1'b0;
    tick(); tick();
    checks++;
    if (duty_count !== 8'd5) begin errors++; $display("FAIL hold_until_commit: duty=%0d, required 5", duty_count); end
    commit();
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL commit_inc_coarse: duty=%0d, required %0d", duty_count, exp[7:0]); end

    exp_q.push_back({8'd10, 8'd6});
    inc_fine = 1'b1; dec_fine = 1'b1; tick(); inc_fine = 1'b0; dec_fine = 1'b0;
    commit();
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL fine_cancel: duty=%0d, required %0d", duty_count, exp[7:0]); end

    exp_q.push_back({8'd10, 8'd7});
    inc_coarse = 1'b1; period_end = 1'b1; tick(); inc_coarse = 1'b0; period_end = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL same_cycle_commit: duty=%0d, required %0d", duty_count, exp[7:0]); end
  endtask

  task automatic test_mode_switch;
    int first, lows;
    inc_coarse = 1'b1; tick(); inc_coarse = 1'b0;   // leave something pending
    exp_q.push_back({8'd20, 8'd10});
    mode_sel = 2'b01;
    first = 0; lows = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (gen_srst === 1'b1 && first == 0) begin
        first = i;
        exp = exp_q.pop_front();
        checks++;
        if (div_value !== exp[15:8] || duty_count !== exp[7:0]) begin
          errors++;
          $display("FAIL switch_cfg: div=%0d duty=%0d, required %0d %0d", div_value, duty_count, exp[15:8], exp[7:0]);
        end
      end
      if (cfg_valid !== 1'b1) lows++;
    end
    checks++;
    if (first !== 4) begin errors++; $display("FAIL switch_latency: gen_srst at cycle %0d, required 4", first); end
    checks++;
    if (lows !== 3) begin errors++; $display("FAIL switch_valid_low: %0d cycles, required 3", lows); end
    commit();
    checks++;
    if (duty_count !== 8'd10) begin errors++; $display("FAIL pending_dropped: duty=%0d, required 10", duty_count); end
  endtask

  task automatic test_saturation;
    switch_mode(2'b10);
    checks++;
    if (div_value !== 8'd100 || duty_count !== 8'd50) begin
      errors++; $display("FAIL slow_profile: div=%0d duty=%0d, required 100 50", div_value, duty_count);
    end
    exp_q.push_back({8'd100, 8'd100});
    repeat (6) begin inc_coarse = 1'b1; tick(); inc_coarse = 1'b0; end
    commit();
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL sat_high: duty=%0d, required %0d", duty_count, exp[7:0]); end
    exp_q.push_back({8'd100, 8'd0});
    repeat (12) begin dec_coarse = 1'b1; tick(); dec_coarse = 1'b0; end
    commit();
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL sat_low: duty=%0d, required %0d", duty_count, exp[7:0]); end
    exp_q.push_back({8'd100, 8'd1});
    inc_fine = 1'b1; tick(); inc_fine = 1'b0;
    commit();
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL pending_cleared: duty=%0d, required %0d", duty_count, exp[7:0]); end
  endtask

  task automatic test_immediate;
    switch_mode(2'b10);
    exp_q.push_back({8'd100, 8'd51});
    inc_fine = 1'b1; tick(); inc_fine = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL immediate_fine: duty=%0d, required %0d", duty_count, exp[7:0]); end
    exp_q.push_back({8'd100, 8'd100});
    repeat (6) begin inc_coarse = 1'b1; tick(); inc_coarse = 1'b0; end
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL immediate_sat: duty=%0d, required %0d", duty_count, exp[7:0]); end
    exp_q.push_back({8'd100, 8'd99});
    dec_fine = 1'b1; tick(); dec_fine = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (duty_count !== exp[7:0]) begin errors++; $display("FAIL immediate_dec: duty=%0d, required %0d", duty_count, exp[7:0]); end
  endtask

  task automatic test_mid_reset;
    int pulses;
    repeat (2) begin inc_coarse = 1'b1; tick(); inc_coarse = 1'b0; end
    srst = 1'b1; tick(); srst = 1'b0;
    checks++;
    if (div_value !== 8'd10 || duty_count !== 8'd5 || busy !== 1'b1 || gen_srst !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: div=%0d duty=%0d busy=%b gen=%b, required 10 5 1 0", div_value, duty_count, busy, gen_srst);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (gen_srst === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL mid_reset_no_pulse: got %0d pulses, required 0", pulses); end
  endtask

  // Continues from the INIT_WAIT left by test_mid_reset, mode_sel still 10.
  task automatic test_ignored;
    int n;
    exp_q.push_back({8'd100, 8'd50});
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      inc_coarse = 1'b1; inc_fine = 1'b1; period_end = n[0];
      tick();
      n++;
    end
    inc_coarse = 1'b0; inc_fine = 1'b0; period_end = 1'b0;
    checks++;
    if (n >= 40) begin errors++; $display("FAIL ignored_timeout: still busy after %0d cycles", n); end
    exp = exp_q.pop_front();
    checks++;
    if (div_value !== exp[15:8] || duty_count !== exp[7:0]) begin
      errors++;
      $display("FAIL ignored_entry: div=%0d duty=%0d, required %0d %0d", div_value, duty_count, exp[15:8], exp[7:0]);
    end
    commit();
    checks++;
    if (duty_count !== 8'd50) begin errors++; $display("FAIL ignored_no_pending: duty=%0d, required 50", duty_count); end
  endtask

  initial begin
    test_reset();
`ifdef PWM_CFG_IMMEDIATE_EN
    test_mode_switch();
    test_immediate();
`else
    test_boundary();
    test_mode_switch();
    test_saturation();
`endif
    test_mid_reset();
    test_ignored();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
